// File: rtl/goertzel_feeder.sv
// Front-end sequencer for the multi-bin Goertzel engine: bin programming, sample streaming, result capture/drain.
// Optional watchdog on the engine wait states is enabled by defining GOERTZEL_FEEDER_TIMEOUT_EN.
module goertzel_feeder #(
   parameter int N_MAX     = 32,
   parameter int WIDTH     = 16,
   parameter int BIN_NUM   = 1,
   parameter int LOG_N_MAX = $clog2(N_MAX)
) (
   input  logic                        i_sys_clk,
   input  logic                        i_sys_rst_n,
   input  logic                        i_start,
   input  logic [$clog2(LOG_N_MAX):0]  i_N,
   input  logic                        i_k_wr,
   input  logic [$clog2(BIN_NUM):0]    i_k_addr,
   input  logic [LOG_N_MAX-1:0]        i_k_data,
   input  logic                        i_s_valid,
   input  logic [WIDTH-1:0]            i_s_data,
   output logic                        o_s_ready,
   output logic [LOG_N_MAX:0]          o_k,
   output logic [$clog2(LOG_N_MAX):0]  o_N,
   output logic [WIDTH-1:0]            o_x,
   output logic                        o_enable,
   input  logic                        i_g_ready,
   input  logic                        i_g_done,
   input  logic [WIDTH-1:0]            i_g_re,
   input  logic [WIDTH-1:0]            i_g_im,
   output logic                        o_r_valid,
   input  logic                        i_r_ready,
   output logic [WIDTH-1:0]            o_r_re,
   output logic [WIDTH-1:0]            o_r_im,
   output logic [$clog2(BIN_NUM):0]    o_r_bin,
   output logic                        o_busy,
   output logic                        o_err
);

   localparam int NW = $clog2(LOG_N_MAX) + 1;
   localparam int BW = $clog2(BIN_NUM) + 1;
   localparam int IW = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
   localparam int CW = LOG_N_MAX + 1;
   localparam int KW = LOG_N_MAX + 1;

   localparam logic [BW-1:0] BIN_LAST = BW'(BIN_NUM - 1);
   localparam logic [NW-1:0] N_CLAMP  = NW'(LOG_N_MAX);
   localparam logic [KW-1:0] K_SENT   = KW'(N_MAX);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SENT      = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_WAIT_RDY  = 3'd3;
   localparam logic [2:0] S_STREAM    = 3'd4;
   localparam logic [2:0] S_WAIT_DONE = 3'd5;
   localparam logic [2:0] S_COLLECT   = 3'd6;
   localparam logic [2:0] S_DRAIN     = 3'd7;

   logic [2:0]           state_r;
   logic [NW-1:0]        n_r;
   logic [BW-1:0]        bin_r;
   logic [CW-1:0]        smp_r;
   logic [LOG_N_MAX-1:0] k_table_r [BIN_NUM];
   logic [WIDTH-1:0]     slot_re_r [BIN_NUM];
   logic [WIDTH-1:0]     slot_im_r [BIN_NUM];

   logic [BW-1:0]        bin_nxt_s;
   logic [BW-1:0]        rbin_nxt_s;
   logic [CW-1:0]        frame_last_s;
   logic                 timeout_s;

   assign bin_nxt_s    = bin_r + {{(BW-1){1'b0}}, 1'b1};
   assign rbin_nxt_s   = o_r_bin + {{(BW-1){1'b0}}, 1'b1};
   assign frame_last_s = ({{(CW-1){1'b0}}, 1'b1} << n_r) - {{(CW-1){1'b0}}, 1'b1};
   assign o_busy       = (state_r != S_IDLE);
   assign o_N          = n_r;

`ifdef GOERTZEL_FEEDER_TIMEOUT_EN
   localparam int WW = $clog2(4 * N_MAX) + 1;
   localparam logic [WW-1:0] WD_LAST = WW'(4 * N_MAX - 1);

   logic [WW-1:0] wd_r;
   logic          waiting_s;

   assign waiting_s = (state_r == S_WAIT_RDY) || (state_r == S_WAIT_DONE);
   assign timeout_s = waiting_s && (wd_r == WD_LAST);

   // Watchdog: counts cycles inside a wait state, restarts from zero on every entry
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         wd_r <= {WW{1'b0}};
      end else if (waiting_s && !timeout_s) begin
         wd_r <= wd_r + {{(WW-1){1'b0}}, 1'b1};
      end else begin
         wd_r <= {WW{1'b0}};
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Bin table: host writes land only while idle, out-of-range addresses dropped
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         for (int i = 0; i < BIN_NUM; i++) k_table_r[i] <= {LOG_N_MAX{1'b0}};
      end else if ((state_r == S_IDLE) && i_k_wr && (i_k_addr <= BIN_LAST)) begin
         k_table_r[i_k_addr[IW-1:0]] <= i_k_data;
      end
   end

   // Result slots: one engine result pair per cycle while collecting
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         for (int i = 0; i < BIN_NUM; i++) begin
            slot_re_r[i] <= {WIDTH{1'b0}};
            slot_im_r[i] <= {WIDTH{1'b0}};
         end
      end else if (state_r == S_COLLECT) begin
         slot_re_r[bin_r[IW-1:0]] <= i_g_re;
         slot_im_r[bin_r[IW-1:0]] <= i_g_im;
      end
   end

   // Frame sequencer with registered engine-side and result-side outputs
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_r   <= S_IDLE;
         n_r       <= {NW{1'b0}};
         bin_r     <= {BW{1'b0}};
         smp_r     <= {CW{1'b0}};
         o_k       <= {KW{1'b0}};
         o_x       <= {WIDTH{1'b0}};
         o_enable  <= 1'b0;
         o_s_ready <= 1'b0;
         o_r_valid <= 1'b0;
         o_r_re    <= {WIDTH{1'b0}};
         o_r_im    <= {WIDTH{1'b0}};
         o_r_bin   <= {BW{1'b0}};
         o_err     <= 1'b0;
      end else begin
         o_enable <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (i_start) begin
                  n_r     <= (i_N > N_CLAMP) ? N_CLAMP : i_N;
                  o_err   <= 1'b0;
                  o_k     <= K_SENT;
                  state_r <= S_SENT;
               end
            end
            S_SENT: begin
               o_k     <= {1'b0, k_table_r[0]};
               bin_r   <= {BW{1'b0}};
               state_r <= S_LOAD;
            end
            S_LOAD: begin
               if (bin_r == BIN_LAST) begin
                  o_k     <= {KW{1'b0}};
                  bin_r   <= {BW{1'b0}};
                  state_r <= S_WAIT_RDY;
               end else begin
                  o_k   <= {1'b0, k_table_r[bin_nxt_s[IW-1:0]]};
                  bin_r <= bin_nxt_s;
               end
            end
            S_WAIT_RDY: begin
               if (timeout_s) begin
                  o_err   <= 1'b1;
                  state_r <= S_IDLE;
               end else if (i_g_ready) begin
                  smp_r     <= {CW{1'b0}};
                  o_s_ready <= 1'b1;
                  state_r   <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (i_s_valid && o_s_ready) begin
                  o_x      <= i_s_data;
                  o_enable <= 1'b1;
                  // ready falls together with the final transfer so no extra sample slips in
                  if (smp_r == frame_last_s) begin
                     o_s_ready <= 1'b0;
                     state_r   <= S_WAIT_DONE;
                  end else begin
                     smp_r <= smp_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            S_WAIT_DONE: begin
               if (timeout_s) begin
                  o_err   <= 1'b1;
                  state_r <= S_IDLE;
               end else if (i_g_done) begin
                  bin_r   <= {BW{1'b0}};
                  state_r <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (bin_r == BIN_LAST) begin
                  // with a single bin, slot 0 is being written this very cycle
                  o_r_re    <= (bin_r == {BW{1'b0}}) ? i_g_re : slot_re_r[0];
                  o_r_im    <= (bin_r == {BW{1'b0}}) ? i_g_im : slot_im_r[0];
                  o_r_bin   <= {BW{1'b0}};
                  o_r_valid <= 1'b1;
                  bin_r     <= {BW{1'b0}};
                  state_r   <= S_DRAIN;
               end else begin
                  bin_r <= bin_nxt_s;
               end
            end
            S_DRAIN: begin
               if (i_r_ready) begin
                  if (o_r_bin == BIN_LAST) begin
                     o_r_valid <= 1'b0;
                     state_r   <= S_IDLE;
                  end else begin
                     o_r_bin <= rbin_nxt_s;
                     o_r_re  <= slot_re_r[rbin_nxt_s[IW-1:0]];
                     o_r_im  <= slot_im_r[rbin_nxt_s[IW-1:0]];
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_goertzel_feeder.sv
// Self-checking bench for goertzel_feeder: table-driven frames checked against a queue-based frame model.
module tb_goertzel_feeder;

   localparam int N_MAX   = 32;
   localparam int WIDTH   = 16;
   localparam int BIN_NUM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [3:0]  i_N = 4'd0;
   logic        i_k_wr = 1'b0;
   logic [2:0]  i_k_addr = 3'd0;
   logic [4:0]  i_k_data = 5'd0;
   logic        i_s_valid = 1'b0;
   logic [15:0] i_s_data = 16'd0;
   logic        o_s_ready;
   logic [5:0]  o_k;
   logic [3:0]  o_N;
   logic [15:0] o_x;
   logic        o_enable;
   logic        i_g_ready = 1'b0;
   logic        i_g_done = 1'b0;
   logic [15:0] i_g_re = 16'd0;
   logic [15:0] i_g_im = 16'd0;
   logic        o_r_valid;
   logic        i_r_ready = 1'b0;
   logic [15:0] o_r_re;
   logic [15:0] o_r_im;
   logic [2:0]  o_r_bin;
   logic        o_busy;
   logic        o_err;

   goertzel_feeder #(.N_MAX(N_MAX), .WIDTH(WIDTH), .BIN_NUM(BIN_NUM)) dut (
      .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_start(i_start), .i_N(i_N),
      .i_k_wr(i_k_wr), .i_k_addr(i_k_addr), .i_k_data(i_k_data),
      .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
      .o_k(o_k), .o_N(o_N), .o_x(o_x), .o_enable(o_enable),
      .i_g_ready(i_g_ready), .i_g_done(i_g_done), .i_g_re(i_g_re), .i_g_im(i_g_im),
      .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_re(o_r_re), .o_r_im(o_r_im),
      .o_r_bin(o_r_bin), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   logic [4:0]  tbl_m [BIN_NUM];
   logic [15:0] res_re_m [BIN_NUM];
   logic [15:0] res_im_m [BIN_NUM];
   logic [15:0] x_m = 16'd0;

   typedef struct {
      int n_in;
      int n_exp;
      int vmode;
      int hold;
      bit sw;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input int data, input bit lands);
      i_k_wr = 1'b1; i_k_addr = addr[2:0]; i_k_data = data[4:0];
      tick();
      i_k_wr = 1'b0;
      if (lands) tbl_m[addr] = data[4:0];
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      i_start = 1'b0; i_k_wr = 1'b0; i_s_valid = 1'b0; i_g_ready = 1'b0;
      i_g_done = 1'b0; i_r_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < BIN_NUM; i++) tbl_m[i] = 5'd0;
      x_m = 16'd0;
      tick();
   endtask

   task automatic run_frame(input int n_in, input int n_exp, input int vmode,
                            input int hold, input bit sw, input bit seq_data);
      int flen, sent, cyc, pulses;
      bit v;
      logic [15:0] d;
      flen = 1 << n_exp;
      if (sw) begin
         d = 16'($urandom);
         i_k_wr = 1'b1; i_k_addr = 3'd2; i_k_data = d[4:0];
         tbl_m[2] = d[4:0];
      end
      i_N = n_in[3:0]; i_start = 1'b1;
      tick();
      i_start = 1'b0; i_k_wr = 1'b0;
      chk("busy_at_start", o_busy, 1);
      chk("o_k_sentinel", o_k, N_MAX);
      chk("o_N_latched", o_N, n_exp);
      chk("err_cleared", o_err, 0);
      for (int b = 0; b < BIN_NUM; b++) begin
         tick();
         chk("o_k_bin", o_k, tbl_m[b]);
      end
      tick();
      chk("o_k_after_load", o_k, 0);
      repeat ($urandom_range(0, 3)) begin
         tick();
         chk("s_ready_wait_rdy", o_s_ready, 0);
      end
      i_g_ready = 1'b1;
      tick();
      i_g_ready = 1'b0;
      sent = 0; cyc = 0; pulses = 0;
      while (sent < flen && cyc < 400) begin
         chk("s_ready_stream", o_s_ready, 1);
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d = seq_data ? 16'(sent + 1) : 16'($urandom);
         i_s_valid = v; i_s_data = d;
         tick();
         cyc++;
         if (v) begin
            sent++;
            x_m = d;
         end
         chk("o_enable", o_enable, int'(v));
         chk("o_x", o_x, x_m);
         pulses += int'(o_enable);
      end
      if (cyc >= 400) chk("stream_budget", 0, 1);
      chk("s_ready_after_frame", o_s_ready, 0);
      chk("enable_pulses", pulses, flen);
      i_s_valid = 1'b1; i_s_data = 16'hdead;
      repeat (2) begin
         tick();
         chk("no_extra_sample", o_enable, 0);
      end
      i_s_valid = 1'b0;
      i_k_wr = 1'b1; i_k_addr = 3'($urandom_range(0, BIN_NUM - 1)); i_k_data = 5'($urandom);
      repeat ($urandom_range(1, 4)) begin
         tick();
         chk("r_valid_wait_done", o_r_valid, 0);
      end
      i_k_wr = 1'b0;
      i_g_done = 1'b1;
      tick();
      i_g_done = 1'b0;
      for (int c = 0; c < BIN_NUM; c++) begin
         chk("r_valid_collect", o_r_valid, 0);
         i_g_re = res_re_m[c]; i_g_im = res_im_m[c];
         tick();
      end
      i_g_re = 16'($urandom); i_g_im = 16'($urandom);
      for (int r = 0; r < BIN_NUM; r++) begin
         for (int h = 0; h <= hold; h++) begin
            chk("r_valid", o_r_valid, 1);
            chk("r_bin", o_r_bin, r);
            chk("r_re", o_r_re, res_re_m[r]);
            chk("r_im", o_r_im, res_im_m[r]);
            if (h < hold) tick();
         end
         i_r_ready = 1'b1;
         tick();
         i_r_ready = 1'b0;
      end
      chk("r_valid_end", o_r_valid, 0);
      chk("busy_end", o_busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{n_in: 0,  n_exp: 0, vmode: 2, hold: 0, sw: 1'b0};
      vecs[1] = '{n_in: 2,  n_exp: 2, vmode: 1, hold: 2, sw: 1'b0};
      vecs[2] = '{n_in: 1,  n_exp: 1, vmode: 1, hold: 1, sw: 1'b1};
      vecs[3] = '{n_in: 5,  n_exp: 5, vmode: 2, hold: 0, sw: 1'b1};
      vecs[4] = '{n_in: 6,  n_exp: 5, vmode: 0, hold: 1, sw: 1'b0};
      vecs[5] = '{n_in: 15, n_exp: 5, vmode: 2, hold: 3, sw: 1'b1};

      apply_reset();
      chk("rst_o_k", o_k, 0);
      chk("rst_o_N", o_N, 0);
      chk("rst_o_x", o_x, 0);
      chk("rst_o_enable", o_enable, 0);
      chk("rst_s_ready", o_s_ready, 0);
      chk("rst_r_valid", o_r_valid, 0);
      chk("rst_r_re", o_r_re, 0);
      chk("rst_r_bin", o_r_bin, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);

      // directed frame: table {1,3,5,7}, N=3, samples 1..8, results held for 5 cycles
      wr(0, 1, 1'b1); wr(1, 3, 1'b1); wr(2, 5, 1'b1); wr(3, 7, 1'b1);
      for (int i = 0; i < BIN_NUM; i++) begin
         res_re_m[i] = 16'(10 * (i + 1));
         res_im_m[i] = 16'(-10 * (i + 1));
      end
      run_frame(3, 3, 0, 5, 1'b0, 1'b1);

      for (int a = 4; a < 8; a++) wr(a, int'($urandom_range(0, 31)), 1'b0);

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < BIN_NUM; i++) begin
            wr(i, int'($urandom_range(0, 31)), 1'b1);
            res_re_m[i] = 16'($urandom);
            res_im_m[i] = 16'($urandom);
         end
         run_frame(vecs[v].n_in, vecs[v].n_exp, vecs[v].vmode, vecs[v].hold, vecs[v].sw, 1'b0);
      end

`ifdef GOERTZEL_FEEDER_TIMEOUT_EN
      i_N = 4'd2; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (BIN_NUM + 1) tick();
      repeat (127) tick();
      chk("wd_err_before", o_err, 0);
      chk("wd_busy_before", o_busy, 1);
      tick();
      chk("wd_err_set", o_err, 1);
      chk("wd_back_idle", o_busy, 0);
      repeat (3) tick();
      chk("wd_err_sticky", o_err, 1);
      run_frame(2, 2, 0, 0, 1'b0, 1'b0);
`else
      i_N = 4'd2; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (BIN_NUM + 1) tick();
      repeat (1000) tick();
      chk("nowd_still_busy", o_busy, 1);
      chk("nowd_no_err", o_err, 0);
      chk("nowd_no_ready", o_s_ready, 0);
      apply_reset();
`endif

      // asynchronous reset in the middle of a stream
      for (int i = 0; i < BIN_NUM; i++) wr(i, int'($urandom_range(1, 31)), 1'b1);
      i_N = 4'd4; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (BIN_NUM + 1) tick();
      i_g_ready = 1'b1;
      tick();
      i_g_ready = 1'b0;
      i_s_valid = 1'b1; i_s_data = 16'h1234;
      repeat (2) tick();
      chk("pre_reset_enable", o_enable, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_enable", o_enable, 0);
      chk("arst_s_ready", o_s_ready, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_o_x", o_x, 0);
      chk("arst_o_N", o_N, 0);
      chk("arst_r_valid", o_r_valid, 0);
      apply_reset();
      for (int i = 0; i < BIN_NUM; i++) begin
         wr(i, int'($urandom_range(0, 31)), 1'b1);
         res_re_m[i] = 16'($urandom);
         res_im_m[i] = 16'($urandom);
      end
      run_frame(4, 4, 2, 1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
